// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sharing of the single-port data memory between CPU (port 0) and loader (port 1).
module dm_arbiter #(
  parameter int DATA_WIDTH       = 16,
  parameter int DM_ADDRESS_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0,
  input  logic                        we0,
  input  logic [DM_ADDRESS_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]       d0,
  output logic                        gnt0,
  output logic                        rvalid0,
  output logic [DATA_WIDTH-1:0]       q0,
  input  logic                        req1,
  input  logic                        we1,
  input  logic [DM_ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]       d1,
  output logic                        gnt1,
  output logic                        rvalid1,
  output logic [DATA_WIDTH-1:0]       q1,
  output logic                        dm_we,
  output logic [DATA_WIDTH-1:0]       dm_D,
  output logic [DM_ADDRESS_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0]       dm_Q
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t                      state_q, state_d;
  logic                        last_q, last_d, id_q, id_d, we_q, we_d, win;
  logic [DM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       d_q, d_d, q0_q, q0_d, q1_q, q1_d;
  // Under contention the port that was not served last wins.
  assign win = (req0 && req1) ? ~last_q : req1;
  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    d_d     = d_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    if (state_q == ACCESS) begin
      state_d = RESP;
      last_d  = id_q;
      q0_d    = (!we_q && !id_q) ? dm_Q : q0_q;
      q1_d    = (!we_q && id_q) ? dm_Q : q1_q;
    end else if (req0 || req1) begin
      state_d = ACCESS;
      id_d    = win;
      we_d    = win ? we1 : we0;
      addr_d  = win ? addr1 : addr0;
      d_d     = win ? d1 : d0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      d_q     <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
    end
  end
  assign gnt0    = (state_q == ACCESS) && !id_q;
  assign gnt1    = (state_q == ACCESS) && id_q;
  assign rvalid0 = (state_q == RESP) && !we_q && !id_q;
  assign rvalid1 = (state_q == RESP) && !we_q && id_q;
  assign dm_we   = (state_q == ACCESS) && we_q;
  assign dm_D    = d_q;
  assign dm_addr = addr_q;
  assign q0      = q0_q;
  assign q1      = q1_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios for dm_arbiter against a behavioural 64-word memory.
module tb_dm_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [5:0]  addr0 = 0, addr1 = 0;
  logic [15:0] d0 = 0, d1 = 0;
  logic        gnt0, rvalid0, gnt1, rvalid1, dm_we;
  logic [15:0] q0, q1, dm_D, dm_Q;
  logic [5:0]  dm_addr;
  logic [15:0] mem [64] = '{default: '0};
  int          n_checks = 0, n_fail = 0;

  dm_arbiter #(.DATA_WIDTH(16), .DM_ADDRESS_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .d0(d0), .gnt0(gnt0), .rvalid0(rvalid0), .q0(q0),
    .req1(req1), .we1(we1), .addr1(addr1), .d1(d1), .gnt1(gnt1), .rvalid1(rvalid1), .q1(q1),
    .dm_we(dm_we), .dm_D(dm_D), .dm_addr(dm_addr), .dm_Q(dm_Q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_D;
  assign dm_Q = mem[dm_addr];

  task automatic do_txn(input bit p, input bit we, input logic [5:0] a, input logic [15:0] d);
    bit got = 0;
    if (p) begin req1 = 1; we1 = we; addr1 = a; d1 = d; end
    else begin req0 = 1; we0 = we; addr0 = a; d0 = d; end
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      got = p ? gnt1 : gnt0;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL txn_timeout port %0d: got no gnt, want gnt within 8 cycles", p); end
    req0 = 0; req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_checks++; if ({gnt0, gnt1, rvalid0, rvalid1, dm_we} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, dm_we}); end
    n_checks++; if ({q0, q1, dm_D, dm_addr} !== 54'b0) begin n_fail++; $display("FAIL reset_data: got q0=%h q1=%h D=%h addr=%0d want all 0", q0, q1, dm_D, dm_addr); end
    rst = 0;
  endtask

  task automatic test_write_then_read();
    req0 = 1; we0 = 1; addr0 = 2; d0 = 16'd8;
    req1 = 1; we1 = 0; addr1 = 2;
    @(negedge clk);
    n_checks++; if ({gnt0, gnt1, dm_we} !== 3'b101) begin n_fail++; $display("FAIL t1_access0: got gnt0,gnt1,we=%b want 101", {gnt0, gnt1, dm_we}); end
    n_checks++; if (dm_addr !== 6'd2 || dm_D !== 16'd8) begin n_fail++; $display("FAIL t1_bus: got addr=%0d D=%h want 2/0008", dm_addr, dm_D); end
    req0 = 0;
    @(negedge clk);
    n_checks++; if ({gnt0, gnt1, rvalid0, dm_we} !== 4'b0) begin n_fail++; $display("FAIL t1_resp0: got %b want 0000", {gnt0, gnt1, rvalid0, dm_we}); end
    @(negedge clk);
    n_checks++; if ({gnt0, gnt1, dm_we} !== 3'b010) begin n_fail++; $display("FAIL t1_access1: got gnt0,gnt1,we=%b want 010", {gnt0, gnt1, dm_we}); end
    req1 = 0;
    @(negedge clk);
    n_checks++; if (rvalid1 !== 1'b1 || q1 !== 16'd8 || q0 !== 16'd0) begin n_fail++; $display("FAIL t1_rdata: got rvalid1=%b q1=%h q0=%h want 1/0008/0000", rvalid1, q1, q0); end
  endtask

  task automatic test_first_contention();
    test_reset();
    req0 = 1; we0 = 0; addr0 = 2; req1 = 1; we1 = 0; addr1 = 2;
    @(negedge clk);
    n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL t2_cyc1: got gnt0,gnt1=%b want 10", {gnt0, gnt1}); end
    req0 = 0;
    @(negedge clk);
    n_checks++; if (rvalid0 !== 1'b1 || q0 !== 16'd8 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL t2_cyc2: got rvalid0=%b q0=%h gnt1=%b want 1/0008/0", rvalid0, q0, gnt1); end
    @(negedge clk);
    n_checks++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL t2_cyc3: got gnt0,gnt1=%b want 01", {gnt0, gnt1}); end
    req1 = 0;
    @(negedge clk);
    n_checks++; if (rvalid1 !== 1'b1 || q1 !== 16'd8 || rvalid0 !== 1'b0) begin n_fail++; $display("FAIL t2_cyc4: got rvalid1=%b q1=%h rvalid0=%b want 1/0008/0", rvalid1, q1, rvalid0); end
  endtask

  task automatic test_back_to_back();
    int g0 = 0, g1 = 0;
    bit w;
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 20; d0 = 16'h1000;
    req1 = 1; we1 = 0; addr1 = 20;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        w = ((i / 2) % 2) == 1;
        n_checks++; if ({gnt0, gnt1, dm_we} !== {!w, w, !w}) begin n_fail++; $display("FAIL t3_access i=%0d: got gnt0,gnt1,we=%b want %b", i, {gnt0, gnt1, dm_we}, {!w, w, !w}); end
        if (!w) begin g0++; d0 = 16'h1000 + 16'(g0); if (g0 == 4) req0 = 0; end
        else begin g1++; if (g1 == 4) req1 = 0; end
      end else begin
        w = (((i - 1) / 2) % 2) == 1;
        n_checks++; if ({gnt0, gnt1, dm_we, rvalid0, rvalid1} !== {4'b0, w}) begin n_fail++; $display("FAIL t3_resp i=%0d: got gnt0,gnt1,we,rv0,rv1=%b want %b", i, {gnt0, gnt1, dm_we, rvalid0, rvalid1}, {4'b0, w}); end
        if (w) begin
          n_checks++; if (q1 !== 16'h1000 + 16'((i - 3) / 4)) begin n_fail++; $display("FAIL t3_q1 i=%0d: got %h want %h", i, q1, 16'h1000 + 16'((i - 3) / 4)); end
        end
      end
    end
    n_checks++; if (q0 !== 16'd8) begin n_fail++; $display("FAIL t3_q0_hold: got %h want 0008", q0); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 5; d1 = 16'hBEEF;
    @(negedge clk);
    n_checks++; if ({gnt1, dm_we} !== 2'b11) begin n_fail++; $display("FAIL t4_access: got gnt1,we=%b want 11", {gnt1, dm_we}); end
    #2 rst = 1;
    #1;
    n_checks++; if ({gnt1, dm_we} !== 2'b00) begin n_fail++; $display("FAIL t4_async: got gnt1,we=%b want 00", {gnt1, dm_we}); end
    req1 = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({gnt0, gnt1, rvalid0, rvalid1, dm_we} !== 5'b0) begin n_fail++; $display("FAIL t4_quiet i=%0d: got %b want 00000", i, {gnt0, gnt1, rvalid0, rvalid1, dm_we}); end
    end
    do_txn(0, 0, 2, 0);
    n_checks++; if (q0 !== 16'd8) begin n_fail++; $display("FAIL t4_pre: got %h want 0008", q0); end
    do_txn(0, 0, 5, 0);
    n_checks++; if (rvalid0 !== 1'b1 || q0 !== 16'h0) begin n_fail++; $display("FAIL t4_aborted: got rvalid0=%b q0=%h want 1/0000", rvalid0, q0); end
  endtask

  task automatic test_addr_limits();
    do_txn(0, 1, 63, 16'hFFFF);
    n_checks++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL t5_wr_rvalid: got %b want 0", rvalid0); end
    do_txn(0, 0, 63, 0);
    n_checks++; if (rvalid0 !== 1'b1 || q0 !== 16'hFFFF) begin n_fail++; $display("FAIL t5_rd63: got rvalid0=%b q0=%h want 1/ffff", rvalid0, q0); end
    do_txn(0, 0, 0, 0);
    n_checks++; if (rvalid0 !== 1'b1 || q0 !== 16'h0) begin n_fail++; $display("FAIL t5_rd0: got rvalid0=%b q0=%h want 1/0000", rvalid0, q0); end
  endtask

  task automatic test_idle();
    do_txn(0, 0, 63, 0);
    do_txn(1, 0, 20, 0);
    n_checks++; if (q0 !== 16'hFFFF || q1 !== 16'h1003) begin n_fail++; $display("FAIL t6_setup: got q0=%h q1=%h want ffff/1003", q0, q1); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if ({gnt0, gnt1, rvalid0, rvalid1, dm_we} !== 5'b0 || q0 !== 16'hFFFF || q1 !== 16'h1003) begin n_fail++; $display("FAIL t6_idle i=%0d: got ctl=%b q0=%h q1=%h want 00000/ffff/1003", i, {gnt0, gnt1, rvalid0, rvalid1, dm_we}, q0, q1); end
    end
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_first_contention();
    test_back_to_back();
    test_reset_mid_access();
    test_addr_limits();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
